seg7_display_monitor: RTL and testbench

- Receive-side counterpart of the seven-segment display driver.
- Samples the multiplexed, active-low cathode and anode lines and recovers the four BCD digits being shown.
- Reports per-digit valid and error status, and pulses a strobe on each capture.
- Used for on-board loopback self-check of the counter/decoder chain and as the scoreboard tap in simulation.

---
 rtl/seg7_display_monitor.sv | 187 ++++++++++++++++++
 tb/tb_seg7_display_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_monitor.sv
`default_nettype none
// ============================================================================
// Module   : seg7_display_monitor
// Brief    : Recovers four BCD digits from a multiplexed active-low 7-segment
//            bus. Optional per-digit refresh timeout: SEG7_MON_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_display_monitor #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_cat,
    input  logic [3:0]  seg_an,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  seg_err,
    output logic        update
);

    localparam logic [7:0] c_stable  = 8'(STABLE_CYCLES);
    localparam logic [6:0] c_cat_off = 7'h7F;
    localparam logic [3:0] c_an_off  = 4'hF;

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable
        $error("seg7_display_monitor: STABLE_CYCLES outside 2..255");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 16777216) begin : g_bad_timeout
        $error("seg7_display_monitor: TIMEOUT_CYCLES outside 2..2^24");
    end

    logic [6:0]  r_cat_s1;
    logic [6:0]  r_cat_s2;
    logic [6:0]  r_cat_prev;
    logic [3:0]  r_an_s1;
    logic [3:0]  r_an_s2;
    logic [3:0]  r_an_prev;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic        r_fire;
    logic        w_an_onehot;
    logic [1:0]  w_slot;
    logic        w_legal;
    logic        w_blank;
    logic [3:0]  w_value;
    logic [15:0] r_digits;
    logic [3:0]  r_valid;
    logic [3:0]  r_err;
    logic        r_update;

    // Two-flop synchronizers plus a one-cycle history of the synchronized sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cat_s1   <= c_cat_off;
            r_cat_s2   <= c_cat_off;
            r_cat_prev <= c_cat_off;
            r_an_s1    <= c_an_off;
            r_an_s2    <= c_an_off;
            r_an_prev  <= c_an_off;
        end else begin
            r_cat_s1   <= seg_cat;
            r_cat_s2   <= r_cat_s1;
            r_cat_prev <= r_cat_s2;
            r_an_s1    <= seg_an;
            r_an_s2    <= r_an_s1;
            r_an_prev  <= r_an_s2;
        end
    end

    always_comb begin
        w_an_onehot = 1'b0;
        case (r_an_s2)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: w_an_onehot = 1'b1;
            default:                            w_an_onehot = 1'b0;
        endcase
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_an_onehot) begin
            w_cnt_next = 8'd0;
        end else if ((r_cat_s2 != r_cat_prev) || (r_an_s2 != r_an_prev)) begin
            w_cnt_next = 8'd1;
        end else if (r_cnt != c_stable) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    // r_fire is high only in the first cycle the counter sits at saturation;
    // the stable pattern is then held in the *_prev registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= 8'd0;
            r_fire <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_fire <= (w_cnt_next == c_stable) && (r_cnt != c_stable);
        end
    end

    always_comb begin
        w_slot = 2'd0;
        case (r_an_prev)
            4'b1110: w_slot = 2'd0;
            4'b1101: w_slot = 2'd1;
            4'b1011: w_slot = 2'd2;
            4'b0111: w_slot = 2'd3;
            default: w_slot = 2'd0;
        endcase
    end

    always_comb begin
        w_legal = 1'b1;
        w_blank = 1'b0;
        w_value = 4'hF;
        case (r_cat_prev)
            7'h40: w_value = 4'd0;
            7'h79: w_value = 4'd1;
            7'h24: w_value = 4'd2;
            7'h30: w_value = 4'd3;
            7'h19: w_value = 4'd4;
            7'h12: w_value = 4'd5;
            7'h02: w_value = 4'd6;
            7'h78: w_value = 4'd7;
            7'h00: w_value = 4'd8;
            7'h10: w_value = 4'd9;
            7'h7F: begin
                w_legal = 1'b0;
                w_blank = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

`ifdef SEG7_MON_TIMEOUT_EN
    localparam int unsigned       c_to_w    = 25;
    localparam logic [c_to_w-1:0] c_timeout = c_to_w'(TIMEOUT_CYCLES);
    logic [c_to_w-1:0] r_refresh [4];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_digits <= 16'hFFFF;
            r_valid  <= 4'h0;
            r_err    <= 4'h0;
            r_update <= 1'b0;
`ifdef SEG7_MON_TIMEOUT_EN
            for (int n = 0; n < 4; n++) begin
                r_refresh[n] <= '0;
            end
`endif
        end else begin
            r_update <= r_fire;
`ifdef SEG7_MON_TIMEOUT_EN
            // A digit not rescanned within the timeout is treated as stale.
            for (int n = 0; n < 4; n++) begin
                if (r_fire && (w_slot == 2'(n))) begin
                    r_refresh[n] <= '0;
                end else if (r_refresh[n] != c_timeout) begin
                    r_refresh[n] <= r_refresh[n] + 1'b1;
                    if (r_refresh[n] == (c_timeout - 1'b1)) begin
                        r_valid[n]          <= 1'b0;
                        r_digits[n*4 +: 4]  <= 4'hF;
                    end
                end
            end
`endif
            if (r_fire) begin
                if (w_legal || w_blank) begin
                    r_digits[{w_slot, 2'b00} +: 4] <= w_value;
                    r_valid[w_slot]                <= 1'b1;
                    r_err[w_slot]                  <= 1'b0;
                end else begin
                    r_err[w_slot]                  <= 1'b1;
                end
            end
        end
    end

    assign digits      = r_digits;
    assign digit_valid = r_valid;
    assign seg_err     = r_err;
    assign update      = r_update;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_monitor.sv
`default_nettype none
// Self-checking bench for seg7_display_monitor: directed scenarios followed by
// random segment sequences, all checked against a segment-level reference model.
module tb_seg7_display_monitor;

    localparam int S  = 16;
    localparam int TO = 64;
`ifdef SEG7_MON_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_cat;
    logic [3:0]  seg_an;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  seg_err;
    logic        update;

    seg7_display_monitor #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .seg_cat(seg_cat), .seg_an(seg_an),
        .digits(digits), .digit_valid(digit_valid), .seg_err(seg_err), .update(update)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int upd_seen = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (update === 1'b1) upd_seen <= upd_seen + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int passed = 0;

    // Reference model state: one entry per digit.
    logic [3:0] m_dig [4];
    logic       m_val [4];
    logic       m_err [4];
    int         m_cap [4];
    int         exp_upd = 0;
    logic [6:0] last_cat;
    logic [3:0] last_an;
    int         run_len;
    int         run_start;
    logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int slot_of(input logic [3:0] an);
        int zeros = 0;
        int pos = -1;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                zeros++;
                pos = i;
            end
        end
        return (zeros == 1) ? pos : -1;
    endfunction

    task automatic expire(input int n, input int now);
        if (TO_EN && (now - m_cap[n] >= TO)) begin
            m_dig[n] = 4'hF;
            m_val[n] = 1'b0;
        end
    endtask

    task automatic model_capture(input logic [6:0] cat, input int n, input int tc);
        int found = -1;
        expire(n, tc);
        m_cap[n] = tc;
        exp_upd++;
        for (int k = 0; k < 10; k++) if (codes[k] == cat) found = k;
        if (found >= 0) begin
            m_dig[n] = 4'(found);
            m_val[n] = 1'b1;
            m_err[n] = 1'b0;
        end else if (cat == 7'h7F) begin
            m_dig[n] = 4'hF;
            m_val[n] = 1'b1;
            m_err[n] = 1'b0;
        end else begin
            m_err[n] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_dig[n] = 4'hF;
            m_val[n] = 1'b0;
            m_err[n] = 1'b0;
            m_cap[n] = cyc;
        end
        last_cat = 7'h7F;
        last_an  = 4'hF;
        run_len  = 0;
        run_start = cyc;
    endtask

    task automatic check_model(input string tag);
        logic [15:0] ed;
        logic [3:0]  ev;
        logic [3:0]  ee;
        for (int n = 0; n < 4; n++) begin
            expire(n, cyc);
            ed[n*4 +: 4] = m_dig[n];
            ev[n] = m_val[n];
            ee[n] = m_err[n];
        end
        check({tag, ".digits"}, 32'(digits), 32'(ed));
        check({tag, ".valid"},  32'(digit_valid), 32'(ev));
        check({tag, ".err"},    32'(seg_err), 32'(ee));
        check({tag, ".updates"}, upd_seen, exp_upd);
    endtask

    // Drive one input segment for d cycles; called and returns at clock edge + 1.
    task automatic step(input logic [6:0] cat, input logic [3:0] an, input int d,
                        output int first_k, output int npulse);
        int prev_len;
        if ((cat != last_cat) || (an != last_an)) begin
            run_len   = 0;
            run_start = cyc;
        end
        seg_cat  = cat;
        seg_an   = an;
        last_cat = cat;
        last_an  = an;
        prev_len = run_len;
        run_len += d;
        first_k = -1;
        npulse  = 0;
        for (int k = 1; k <= d; k++) begin
            @(posedge clk);
            #1;
            if (update === 1'b1) begin
                npulse++;
                if (first_k < 0) first_k = k;
            end
        end
        if ((slot_of(an) >= 0) && (prev_len < S) && (run_len >= S))
            model_capture(cat, slot_of(an), run_start + 3 + S);
    endtask

    int fk, np, base_upd;
    logic [6:0] rc;
    logic [3:0] ra;
    int rd;

    initial begin
        rst = 1'b0;
        seg_cat = 7'h7F;
        seg_an  = 4'hF;
        repeat (3) begin @(posedge clk); #1; end
        check("reset.digits", 32'(digits), 32'hFFFF);
        check("reset.valid", 32'(digit_valid), 32'h0);
        check("reset.err", 32'(seg_err), 32'h0);
        check("reset.update", 32'(update), 32'h0);
        rst = 1'b1;
        model_reset();

        // Idle display: nothing may be captured.
        step(7'h7F, 4'hF, 100, fk, np);
        check("idle.pulses", np, 0);
        check_model("idle");

        // Single digit: one pulse exactly 2 + S + 1 cycles after the change.
        step(7'h30, 4'b1110, 20, fk, np);
        check("single.latency", fk, 2 + S + 1);
        check("single.pulses", np, 1);
        check("single.digit0", 32'(digits[3:0]), 32'h3);
        check("single.valid", 32'(digit_valid), 32'b0001);
        check_model("single");

        // Full scan of 1,2,3,4 twice, then a short glitch on digit 2.
        base_upd = upd_seen;
        for (int r = 0; r < 2; r++)
            for (int n = 0; n < 4; n++)
                step(codes[n + 1], 4'(~(4'b0001 << n)), 32, fk, np);
        check("scan.pulses", upd_seen - base_upd, 8);
`ifndef SEG7_MON_TIMEOUT_EN
        check("scan.digits", 32'(digits), 32'h4321);
        check("scan.valid", 32'(digit_valid), 32'hF);
`endif
        check_model("scan");
        step(7'h30, 4'b1011, 32, fk, np);
        step(7'h00, 4'b1011, 5, fk, np);
        check("glitch.pulses", np, 0);
        step(7'h30, 4'b1011, 32, fk, np);
        check_model("glitch");

        // Two anodes low: ignored. Then an illegal pattern on digit 3.
        step(7'h40, 4'b1100, 50, fk, np);
        check("twoan.pulses", np, 0);
        check_model("twoan");
        step(7'h7E, 4'b0111, 20, fk, np);
        check("illegal.pulses", np, 1);
        check("illegal.err", 32'(seg_err), 32'b1000);
        check_model("illegal");

        // Blank on digit 1.
        step(7'h7F, 4'b1101, 20, fk, np);
        check("blank.nibble", 32'(digits[7:4]), 32'hF);
        check("blank.valid1", 32'(digit_valid[1]), 32'h1);
        check_model("blank");

        // Reset in the middle of a window, then a full new window after release.
        step(7'h19, 4'b1110, 10, fk, np);
        rst = 1'b0;
        #1;
        check("midrst.digits", 32'(digits), 32'hFFFF);
        check("midrst.valid", 32'(digit_valid), 32'h0);
        check("midrst.err", 32'(seg_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step(7'h19, 4'b1110, 25, fk, np);
        check("midrst.latency", fk, 2 + S + 1);
        check_model("midrst");

        // Random segments: short glitches and long captures, legal/blank/illegal.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                6:       rc = 7'h7F;
                7:       rc = 7'($urandom);
                default: rc = codes[$urandom_range(0, 9)];
            endcase
            if ($urandom_range(0, 9) < 8) ra = 4'(~(4'b0001 << $urandom_range(0, 3)));
            else                          ra = 4'($urandom);
            if ($urandom_range(0, 1) == 0) rd = $urandom_range(1, S - 1);
            else                           rd = $urandom_range(S + 4, S + 20);
            step(rc, ra, rd, fk, np);
            if (run_len >= S + 4) check_model("rand");
        end

        // Refresh timeout: capture 7 on digit 0, then stop scanning.
        step(7'h7F, 4'hF, 5, fk, np);
        step(7'h78, 4'b1110, 20, fk, np);
        check("to.latency", fk, 2 + S + 1);
        check("to.digit0", 32'(digits[3:0]), 32'h7);
        step(7'h7F, 4'hF, 62, fk, np);
        check("to.valid_before", 32'(digit_valid[0]), 32'h1);
        step(7'h7F, 4'hF, 1, fk, np);
        check("to.valid_after", 32'(digit_valid[0]), TO_EN ? 32'h0 : 32'h1);
        check("to.digit_after", 32'(digits[3:0]), TO_EN ? 32'hF : 32'h7);
        check_model("timeout");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
